// File: rtl/udp_payload_buf.sv
// Frame-store buffer ahead of the UDP generator: keeps whole payload frames, drops bad ones entirely.
// Latency: frame visible 1 cycle after its last byte; read data 1 cycle after i_rd_en.
// Backpressure: none on the write side (overflowing frames are dropped); reads are paced by i_frame_ack/i_rd_en.
module udp_payload_buf #(
  parameter int ADDR_W  = 11,
  parameter int MAX_LEN = 1472
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_wr_data,
  input  logic        i_wr_en,
  input  logic        i_wr_last,
  output logic        o_drop,
  output logic        o_frame_valid,
  output logic [15:0] o_frame_len,
  input  logic        i_frame_ack,
  input  logic        i_rd_en,
  output logic [7:0]  o_rd_data,
  output logic        o_rd_valid,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_drop_cnt
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] PTR_FULL  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [15:0]     MAX_LEN_W = 16'(MAX_LEN);

  typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DISCARD} wstate_t;
  typedef enum logic       {R_IDLE, R_READ} rstate_t;

  wstate_t w_state, w_next;
  rstate_t r_state, r_next;

  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] wr_commit;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] used;
  logic [15:0]     wr_len;
  logic [15:0]     rd_left;

  // committed-length queue
  logic [15:0] lq [4];
  logic [1:0]  lq_wr;
  logic [1:0]  lq_rd;
  logic [2:0]  lq_cnt;

  logic space_ok;
  logic len_ok;
  logic q_full;
  logic wr_act;
  logic wr_err;
  logic wr_ok;
  logic commit;
  logic pop;
  logic rd_fire;

  // Space uses the read pointer as it stood at the start of the cycle,
  // so a same-cycle read never lends space to the write.
  assign used     = wr_ptr - rd_ptr;
  assign space_ok = (used != PTR_FULL);
  assign len_ok   = (wr_len < MAX_LEN_W);
  assign q_full   = (lq_cnt == 3'd4);
  assign wr_act   = i_wr_en && (w_state != W_DISCARD);
  assign wr_err   = wr_act && (!space_ok || !len_ok || (i_wr_last && q_full));
  assign wr_ok    = wr_act && !wr_err;
  assign commit   = wr_ok && i_wr_last;
  assign pop      = (r_state == R_IDLE) && i_frame_ack && (lq_cnt != 3'd0);
  assign rd_fire  = (r_state == R_READ) && i_rd_en;

  assign o_frame_valid = (lq_cnt != 3'd0);
  assign o_frame_len   = (lq_cnt != 3'd0) ? lq[lq_rd] : 16'd0;

  // State registers for both FSMs
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Write FSM next state: an errored byte discards the rest of its frame unless it was the last one
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE, W_FRAME: begin
        if (i_wr_en) begin
          if (i_wr_last)   w_next = W_IDLE;
          else if (wr_err) w_next = W_DISCARD;
          else             w_next = W_FRAME;
        end
      end
      W_DISCARD: begin
        if (i_wr_en && i_wr_last) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Read FSM next state: an ack claims the head frame, the final byte releases it
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: begin
        if (pop) r_next = R_READ;
      end
      R_READ: begin
        if (rd_fire && (rd_left == 16'd1)) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Write-side pointers: speculative advance, committed on last byte, rolled back on error
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      wr_commit <= '0;
      wr_len    <= 16'd0;
    end else if (wr_err) begin
      wr_ptr <= wr_commit;
      wr_len <= 16'd0;
    end else if (wr_ok) begin
      wr_ptr <= wr_ptr + PTR_ONE;
      if (i_wr_last) begin
        wr_commit <= wr_ptr + PTR_ONE;
        wr_len    <= 16'd0;
      end else begin
        wr_len <= wr_len + 16'd1;
      end
    end
  end

  // Payload RAM write port
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[ADDR_W-1:0]] <= i_wr_data;
  end

  // Length queue storage; contents are meaningful only while counted
  always_ff @(posedge clk) begin
    if (commit) lq[lq_wr] <= wr_len + 16'd1;
  end

  // Length queue pointers and occupancy; a commit and a pop together leave the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      lq_wr  <= 2'd0;
      lq_rd  <= 2'd0;
      lq_cnt <= 3'd0;
    end else begin
      if (commit) lq_wr <= lq_wr + 2'd1;
      if (pop)    lq_rd <= lq_rd + 2'd1;
      case ({commit, pop})
        2'b10:   lq_cnt <= lq_cnt + 3'd1;
        2'b01:   lq_cnt <= lq_cnt - 3'd1;
        default: lq_cnt <= lq_cnt;
      endcase
    end
  end

  // Read side: load the frame length on ack, then stream one byte per i_rd_en
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      rd_left      <= 16'd0;
      o_rd_data    <= 8'd0;
      o_rd_valid   <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_rd_valid   <= rd_fire;
      o_frame_done <= rd_fire && (rd_left == 16'd1);
      if (pop) rd_left <= lq[lq_rd];
      if (rd_fire) begin
        o_rd_data <= mem[rd_ptr[ADDR_W-1:0]];
        rd_ptr    <= rd_ptr + PTR_ONE;
        rd_left   <= rd_left - 16'd1;
      end
    end
  end

  // Drop pulse and frame statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      o_drop      <= 1'b0;
      o_frame_cnt <= 16'd0;
      o_drop_cnt  <= 16'd0;
    end else begin
      o_drop <= wr_err;
      if (commit) o_frame_cnt <= o_frame_cnt + 16'd1;
      if (wr_err) o_drop_cnt  <= o_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_udp_payload_buf.sv
// Bench for udp_payload_buf: instance 0 uses default sizing, instance 1 a 16-byte RAM for wrap tests.
// Read bytes are scoreboarded: expectations are queued at i_rd_en, a monitor compares o_rd_data/o_frame_done.
// Control outputs (valid, length, drop, counters) are checked directly after each step.
module tb_udp_payload_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [2];
  logic [7:0]  wr_data [2];
  logic        wr_en   [2];
  logic        wr_last [2];
  logic        ack     [2];
  logic        rd_en   [2];
  logic        drop    [2];
  logic        fvld    [2];
  logic [15:0] flen    [2];
  logic [7:0]  rd_data [2];
  logic        rd_vld  [2];
  logic        fdone   [2];
  logic [15:0] fcnt    [2];
  logic [15:0] dcnt    [2];

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q [$];
  logic [8:0] mon_e;

  udp_payload_buf dut0 (
    .clk(clk), .rst(rst[0]), .i_wr_data(wr_data[0]), .i_wr_en(wr_en[0]), .i_wr_last(wr_last[0]),
    .o_drop(drop[0]), .o_frame_valid(fvld[0]), .o_frame_len(flen[0]), .i_frame_ack(ack[0]),
    .i_rd_en(rd_en[0]), .o_rd_data(rd_data[0]), .o_rd_valid(rd_vld[0]), .o_frame_done(fdone[0]),
    .o_frame_cnt(fcnt[0]), .o_drop_cnt(dcnt[0])
  );

  udp_payload_buf #(.ADDR_W(4)) dut1 (
    .clk(clk), .rst(rst[1]), .i_wr_data(wr_data[1]), .i_wr_en(wr_en[1]), .i_wr_last(wr_last[1]),
    .o_drop(drop[1]), .o_frame_valid(fvld[1]), .o_frame_len(flen[1]), .i_frame_ack(ack[1]),
    .i_rd_en(rd_en[1]), .o_rd_data(rd_data[1]), .o_rd_valid(rd_vld[1]), .o_frame_done(fdone[1]),
    .o_frame_cnt(fcnt[1]), .o_drop_cnt(dcnt[1])
  );

  // Monitor: every presented read byte must match the oldest queued expectation
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rd_vld[u]) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rd_unexpected u=%0d: got data=%h done=%b, none expected", u, rd_data[u], fdone[u]);
        end else begin
          mon_e = exp_q.pop_front();
          if ({fdone[u], rd_data[u]} !== mon_e) begin
            n_err++;
            $display("FAIL rd_byte u=%0d: got done=%b data=%h, expected done=%b data=%h",
                     u, fdone[u], rd_data[u], mon_e[8], mon_e[7:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int u, input logic [7:0] d, input logic last);
    wr_en[u]   = 1'b1;
    wr_data[u] = d;
    wr_last[u] = last;
    tick();
    wr_en[u]   = 1'b0;
    wr_last[u] = 1'b0;
  endtask

  // Write len bytes s, s+1, ...; o_drop must pulse exactly after byte index drop_at (-1: never)
  task automatic wr_frame(input int u, input logic [7:0] s, input int len, input int drop_at);
    for (int i = 0; i < len; i++) begin
      wr(u, s + 8'(i), (i == len - 1));
      chk($sformatf("drop u%0d byte%0d", u, i), {31'd0, drop[u]}, {31'd0, (i == drop_at)});
    end
  endtask

  task automatic ack_frame(input int u);
    ack[u] = 1'b1;
    tick();
    ack[u] = 1'b0;
  endtask

  // Issue n reads expecting s, s+1, ...; frame_done expected on index done_at
  task automatic rd_bytes(input int u, input logic [7:0] s, input int n, input int done_at);
    for (int i = 0; i < n; i++) begin
      rd_en[u] = 1'b1;
      exp_q.push_back({(i == done_at), s + 8'(i)});
      tick();
    end
    rd_en[u] = 1'b0;
    tick();
    tick();
    chk($sformatf("sb_drain u%0d", u), exp_q.size(), 0);
  endtask

  task automatic rd_frame(input int u, input logic [7:0] s, input int len);
    chk($sformatf("fvld u%0d", u), {31'd0, fvld[u]}, 32'd1);
    chk($sformatf("flen u%0d", u), {16'd0, flen[u]}, len);
    ack_frame(u);
    rd_bytes(u, s, len, len - 1);
  endtask

  task automatic chk_zero(input int u);
    chk($sformatf("zero_drop u%0d", u),  {31'd0, drop[u]},   0);
    chk($sformatf("zero_fvld u%0d", u),  {31'd0, fvld[u]},   0);
    chk($sformatf("zero_flen u%0d", u),  {16'd0, flen[u]},   0);
    chk($sformatf("zero_rdat u%0d", u),  {24'd0, rd_data[u]}, 0);
    chk($sformatf("zero_rvld u%0d", u),  {31'd0, rd_vld[u]}, 0);
    chk($sformatf("zero_done u%0d", u),  {31'd0, fdone[u]},  0);
    chk($sformatf("zero_fcnt u%0d", u),  {16'd0, fcnt[u]},   0);
    chk($sformatf("zero_dcnt u%0d", u),  {16'd0, dcnt[u]},   0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; wr_data[u] = 8'd0; wr_en[u] = 1'b0; wr_last[u] = 1'b0;
      ack[u] = 1'b0; rd_en[u] = 1'b0;
    end
    tick();
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    chk_zero(0);
    chk_zero(1);

    // Single 18-byte frame; a stray rd_en and an early ack must both be ignored
    rd_en[0] = 1'b1; tick(); rd_en[0] = 1'b0; tick();
    chk("idle_rd_ignored", {31'd0, rd_vld[0]}, 0);
    ack_frame(0);
    chk("empty_ack_ignored", {31'd0, fvld[0]}, 0);
    wr_frame(0, 8'h01, 18, -1);
    chk("single_fcnt", {16'd0, fcnt[0]}, 1);
    rd_frame(0, 8'h01, 18);
    chk("single_empty", {31'd0, fvld[0]}, 0);

    // Oversize: byte 1473 errors, the trailing bytes are discarded silently
    wr_frame(0, 8'h20, 1475, 1472);
    chk("over_fvld", {31'd0, fvld[0]}, 0);
    chk("over_dcnt", {16'd0, dcnt[0]}, 1);
    wr_frame(0, 8'hF0, 4, -1);
    rd_frame(0, 8'hF0, 4);
    chk("over_fcnt", {16'd0, fcnt[0]}, 2);

    // Queue full: four frames commit, the fifth is dropped on its last byte
    wr_frame(0, 8'h40, 1, -1);
    wr_frame(0, 8'h50, 2, -1);
    wr_frame(0, 8'h60, 3, -1);
    wr_frame(0, 8'h70, 4, -1);
    wr_frame(0, 8'h80, 5, 4);
    chk("qfull_dcnt", {16'd0, dcnt[0]}, 2);
    rd_frame(0, 8'h40, 1);
    rd_frame(0, 8'h50, 2);
    rd_frame(0, 8'h60, 3);
    rd_frame(0, 8'h70, 4);
    chk("qfull_fcnt", {16'd0, fcnt[0]}, 6);
    chk("qfull_empty", {31'd0, fvld[0]}, 0);

    // Ack of frame A coincides with the commit of frame B
    wr_frame(0, 8'hD0, 3, -1);
    wr(0, 8'hE0, 1'b0);
    ack[0] = 1'b1;
    wr(0, 8'hE1, 1'b1);
    ack[0] = 1'b0;
    chk("simul_fvld", {31'd0, fvld[0]}, 1);
    chk("simul_flen", {16'd0, flen[0]}, 2);
    rd_bytes(0, 8'hD0, 3, 2);
    rd_frame(0, 8'hE0, 2);
    chk("simul_fcnt", {16'd0, fcnt[0]}, 8);

    // Reset while mid-read and mid-write
    wr_frame(0, 8'h90, 5, -1);
    ack_frame(0);
    rd_bytes(0, 8'h90, 2, -1);
    wr(0, 8'hA0, 1'b0);
    wr(0, 8'hA1, 1'b0);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk_zero(0);
    wr_frame(0, 8'h33, 6, -1);
    rd_frame(0, 8'h33, 6);
    chk("post_rst_fcnt", {16'd0, fcnt[0]}, 1);

    // Wrap-around on the 16-byte instance
    wr_frame(1, 8'h80, 10, -1);
    rd_frame(1, 8'h80, 10);
    wr_frame(1, 8'hA0, 12, -1);
    wr_frame(1, 8'hC0, 6, 4);
    chk("wrap_dcnt", {16'd0, dcnt[1]}, 1);
    rd_frame(1, 8'hA0, 12);
    chk("wrap_empty", {31'd0, fvld[1]}, 0);
    wr_frame(1, 8'h10, 16, -1);
    rd_frame(1, 8'h10, 16);
    chk("wrap_fcnt", {16'd0, fcnt[1]}, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
